// File: rtl/te_block_scheduler_if.sv
// te_block_scheduler_if: producer-group and encoder-ingress signals of the block scheduler
interface te_block_scheduler_if #(
  parameter int N           = 2,
  parameter int DEPTH       = 8,
  parameter int IRETIRE_LEN = 8,
  parameter int ITYPE_LEN   = 3,
  parameter int CAUSE_LEN   = 5,
  parameter int PRIV_LEN    = 2,
  parameter int XLEN        = 32
);
  logic                          valid_i;
  logic [N-1:0]                  blk_valid_i;
  logic [N*IRETIRE_LEN-1:0]      iretire_i;
  logic [N-1:0]                  ilastsize_i;
  logic [N*ITYPE_LEN-1:0]        itype_i;
  logic [N*CAUSE_LEN-1:0]        cause_i;
  logic [N*XLEN-1:0]             tval_i;
  logic [N*PRIV_LEN-1:0]         priv_i;
  logic [N*XLEN-1:0]             iaddr_i;
  logic                          ready_o;
  logic                          valid_o;
  logic                          ready_i;
  logic [IRETIRE_LEN-1:0]        iretire_o;
  logic                          ilastsize_o;
  logic [ITYPE_LEN-1:0]          itype_o;
  logic [CAUSE_LEN-1:0]          cause_o;
  logic [XLEN-1:0]               tval_o;
  logic [PRIV_LEN-1:0]           priv_o;
  logic [XLEN-1:0]               iaddr_o;
  logic [$clog2(DEPTH):0]        occupancy_o;
  logic                          overflow_o;
  modport master (
    output valid_i, blk_valid_i, iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, iaddr_i, ready_i,
    input  ready_o, valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o, occupancy_o, overflow_o
  );
  modport slave (
    input  valid_i, blk_valid_i, iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, iaddr_i, ready_i,
    output ready_o, valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o, occupancy_o, overflow_o
  );
endinterface

// File: rtl/te_block_scheduler.sv
// te_block_scheduler: compacts up to N trace blocks per cycle into a FIFO and issues one per cycle
module te_block_scheduler #(
  parameter int N           = 2,
  parameter int DEPTH       = 8,
  parameter int IRETIRE_LEN = 8,
  parameter int ITYPE_LEN   = 3,
  parameter int CAUSE_LEN   = 5,
  parameter int PRIV_LEN    = 2,
  parameter int XLEN        = 32
) (
  input logic clk_i,
  input logic rst_i,
  te_block_scheduler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = IRETIRE_LEN + 1 + ITYPE_LEN + CAUSE_LEN + XLEN + PRIV_LEN + XLEN;
  logic [DEPTH-1:0][BW-1:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, k;
  logic [AW-1:0] wa [N];
  logic [BW-1:0] blk [N];
  logic push, pop, drop;
  always_comb begin
    k = '0;
    for (int s = 0; s < N; s++) begin
      wa[s] = wr_ptr + k[AW-1:0];
      k = k + CW'(bus.blk_valid_i[s]);
      blk[s] = {bus.iretire_i[s*IRETIRE_LEN +: IRETIRE_LEN], bus.ilastsize_i[s],
                bus.itype_i[s*ITYPE_LEN +: ITYPE_LEN], bus.cause_i[s*CAUSE_LEN +: CAUSE_LEN],
                bus.tval_i[s*XLEN +: XLEN], bus.priv_i[s*PRIV_LEN +: PRIV_LEN], bus.iaddr_i[s*XLEN +: XLEN]};
    end
  end
  // ready looks only at the registered count so it never races the same-cycle pop
  assign bus.ready_o = (CW'(DEPTH) - count) >= CW'(N);
  assign bus.valid_o = count != '0;
  assign push = bus.valid_i & bus.ready_o;
  assign pop = bus.valid_o & bus.ready_i;
  assign drop = bus.valid_i & ~bus.ready_o & |bus.blk_valid_i;
  assign bus.occupancy_o = count;
  assign {bus.iretire_o, bus.ilastsize_o, bus.itype_o, bus.cause_o, bus.tval_o, bus.priv_o, bus.iaddr_o} = mem[rd_ptr];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      bus.overflow_o <= 1'b0;
    end else begin
      for (int s = 0; s < N; s++)
        if (push && bus.blk_valid_i[s]) mem[wa[s]] <= blk[s];
      wr_ptr <= wr_ptr + (push ? k[AW-1:0] : '0);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (push ? k : '0) - CW'(pop);
      bus.overflow_o <= bus.overflow_o | drop;
    end
  end
endmodule
